// File: rtl/sound_mixer.sv
// rtl/sound_mixer.sv - volume-scaled, click-free audio output stage
//
// Takes a signed 12-bit sample and emits a signed 16-bit sample once every
// CLK_DIV clocks. The volume is applied by an 8-step shift-add multiplier.
// Volume and mute changes are ramped by one LSB per output sample.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   audio_in      signed 12-bit sample from the sound engine
//   volume_in     unsigned 8-bit volume target
//   volume_write  1-cycle strobe that loads volume_in into the volume target
//   mute          level; while high the effective volume target is 0
//   audio_out     signed 16-bit scaled sample, held between updates
//   sample_strobe 1-cycle pulse in the cycle audio_out takes a new value
//   busy          high while the multiplier is running
module sound_mixer #(
    parameter int         CLK_DIV  = 500,
    parameter logic [7:0] VOL_INIT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] audio_in,
    input  logic [7:0]  volume_in,
    input  logic        volume_write,
    input  logic        mute,
    output logic [15:0] audio_out,
    output logic        sample_strobe,
    output logic        busy
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [7:0]       vol_cur;
    logic [7:0]       vol_target;
    logic [7:0]       eff_target;
    logic [19:0]      acc;
    logic [19:0]      mcand;
    logic [7:0]       mplier;
    logic [2:0]       bit_cnt;

    assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign eff_target = mute ? 8'd0 : vol_target;

    // Free-running sample-rate divider; nothing but reset disturbs it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Volume ramp. vol_cur starts at 0 so power-up is a soft fade-in.
    // The step compares against the pre-edge target, so a write or mute
    // change landing on a tick is seen at the next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vol_cur    <= 8'd0;
            vol_target <= VOL_INIT;
        end else begin
            if (volume_write) begin
                vol_target <= volume_in;
            end
            if (tick) begin
                if (vol_cur < eff_target) begin
                    vol_cur <= vol_cur + 8'd1;
                end else if (vol_cur > eff_target) begin
                    vol_cur <= vol_cur - 8'd1;
                end
            end
        end
    end

    // Multiplier sequencer. The sample and the pre-step volume are captured
    // on the tick edge, so later audio_in or volume activity cannot disturb
    // the product being formed. The multiplicand is sign-extended to 20 bits;
    // after at most 7 shifts it still fits, so the top bit can be dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            bit_cnt       <= '0;
            audio_out     <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        acc     <= '0;
                        mcand   <= {{8{audio_in[11]}}, audio_in};
                        mplier  <= vol_cur;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= {mcand[18:0], 1'b0};
                    mplier  <= {1'b0, mplier[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    // Dropping the low nibble of a two's-complement value floors.
                    audio_out     <= acc[19:4];
                    sample_strobe <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
